// File: rtl/io_timer_pkg.sv
// Shared constants for the IO timer responder: register offsets, CTRL/STAT bit
// positions and the default window base.
package io_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'hFFFFFC20;

  localparam logic [3:0] OFF_CTRL0 = 4'h0;
  localparam logic [3:0] OFF_CTRL1 = 4'h2;
  localparam logic [3:0] OFF_CNT0  = 4'h4;
  localparam logic [3:0] OFF_CNT1  = 4'h6;

  localparam int CTRL_MODE   = 0;
  localparam int CTRL_REPEAT = 1;
  localparam int CTRL_IRQ    = 2;

  localparam int STAT_TDONE = 0;
  localparam int STAT_CDONE = 1;
  localparam int STAT_RUN   = 15;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL0,
    REG_CTRL1,
    REG_CNT0,
    REG_CNT1
  } reg_sel_e;

  // Odd offsets and 0x8-0xE fall through to REG_NONE.
  function automatic reg_sel_e decode_off(input logic [3:0] off);
    case (off)
      OFF_CTRL0: decode_off = REG_CTRL0;
      OFF_CTRL1: decode_off = REG_CTRL1;
      OFF_CNT0:  decode_off = REG_CNT0;
      OFF_CNT1:  decode_off = REG_CNT1;
      default:   decode_off = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_timer_responder_channel.sv
// One timer/counter channel: CTRL/CNT registers, pulse synchronizer with edge
// detect, decrement/terminal logic and clear-on-read done flags.
module timer_channel
  import io_timer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_we,
  input  logic        cnt_we,
  input  logic        stat_rd,
  input  logic        pulse_in,
  input  logic [15:0] wdata,
  output logic [15:0] stat,
  output logic [15:0] count,
  output logic        cout,
  output logic        irq_nxt
);

  logic [2:0]       ctrl_q, ctrl_nxt;
  logic [CNT_W-1:0] init_q, init_nxt;
  logic [CNT_W-1:0] cur_q, cur_nxt;
  logic             run_q, run_nxt;
  logic [1:0]       done_q, done_nxt, done_set;
  logic [2:0]       sync_q;
  logic             rise, dec, term;

  // sync_q[0]/[1] form the synchronizer, sync_q[2] is the edge-detect history.
  assign rise = sync_q[1] & ~sync_q[2];
  assign dec  = run_q & (ctrl_q[CTRL_MODE] ? rise : 1'b1);
  assign term = dec & (cur_q == CNT_W'(1));

  always_comb begin
    ctrl_nxt = ctrl_q;
    if (ctrl_we) begin
      ctrl_nxt[CTRL_MODE]   = wdata[0];
      ctrl_nxt[CTRL_REPEAT] = wdata[1];
`ifdef IO_TIMER_IRQ_EN
      ctrl_nxt[CTRL_IRQ]    = wdata[2];
`else
      ctrl_nxt[CTRL_IRQ]    = 1'b0;
`endif
    end
  end

  // A CNT write in the terminal cycle overrides the reload, but done/cout still fire.
  always_comb begin
    init_nxt = init_q;
    cur_nxt  = cur_q;
    run_nxt  = run_q;
    if (dec) begin
      if (term) begin
        cur_nxt = ctrl_q[CTRL_REPEAT] ? init_q : '0;
        run_nxt = ctrl_q[CTRL_REPEAT];
      end else begin
        cur_nxt = cur_q - CNT_W'(1);
      end
    end
    if (cnt_we) begin
      init_nxt = wdata[CNT_W-1:0];
      cur_nxt  = wdata[CNT_W-1:0];
      run_nxt  = |wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    done_set = 2'b00;
    done_set[ctrl_q[CTRL_MODE]] = term;
    done_nxt = (stat_rd ? 2'b00 : done_q) | done_set;
  end

  assign irq_nxt = ctrl_nxt[CTRL_IRQ] & (|done_nxt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      init_q <= '0;
      cur_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 2'b00;
      sync_q <= 3'b000;
      cout   <= 1'b0;
    end else begin
      ctrl_q <= ctrl_nxt;
      init_q <= init_nxt;
      cur_q  <= cur_nxt;
      run_q  <= run_nxt;
      done_q <= done_nxt;
      sync_q <= {sync_q[1:0], pulse_in};
      cout   <= term;
    end
  end

  always_comb begin
    stat = '0;
    stat[STAT_RUN]   = run_q;
    stat[STAT_TDONE] = done_q[0];
    stat[STAT_CDONE] = done_q[1];
  end

  assign count = 16'(cur_q);

endmodule

// File: rtl/io_timer_responder.sv
// Two-channel memory-mapped timer/counter on the IO bus: address decode and
// registered read mux. Optional Irq output is enabled by IO_TIMER_IRQ_EN.
module io_timer_responder
  import io_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE,
  parameter int          CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        IO_read,
  input  logic        IO_write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  input  logic        Pulse_in0,
  input  logic        Pulse_in1,
  output logic        Cout0,
  output logic        Cout1
`ifdef IO_TIMER_IRQ_EN
  ,
  output logic        Irq
`endif
);

  // Bus contract: no handshake. A selected access is accepted in the cycle it is
  // presented; writes land at the closing edge and read data appears one cycle
  // later. A simultaneous read and write performs only the write.
  logic        sel, wr, rd;
  reg_sel_e    rsel;
  logic [15:0] stat0, stat1, count0, count1, rd_mux;
  logic [1:0]  irq_nxt;
  logic        unused_wdata;

  assign sel  = (IO_read | IO_write) & (Address[31:4] == BASE_ADDR[31:4]);
  assign rsel = decode_off(Address[3:0]);
  assign wr   = sel & IO_write;
  assign rd   = sel & IO_read & ~IO_write;

  assign unused_wdata = ^Write_data[31:16];

  timer_channel #(.CNT_W(CNT_W)) u_ch0 (
    .clock   (clock),
    .reset_n (reset_n),
    .ctrl_we (wr & (rsel == REG_CTRL0)),
    .cnt_we  (wr & (rsel == REG_CNT0)),
    .stat_rd (rd & (rsel == REG_CTRL0)),
    .pulse_in(Pulse_in0),
    .wdata   (Write_data[15:0]),
    .stat    (stat0),
    .count   (count0),
    .cout    (Cout0),
    .irq_nxt (irq_nxt[0])
  );

  timer_channel #(.CNT_W(CNT_W)) u_ch1 (
    .clock   (clock),
    .reset_n (reset_n),
    .ctrl_we (wr & (rsel == REG_CTRL1)),
    .cnt_we  (wr & (rsel == REG_CNT1)),
    .stat_rd (rd & (rsel == REG_CTRL1)),
    .pulse_in(Pulse_in1),
    .wdata   (Write_data[15:0]),
    .stat    (stat1),
    .count   (count1),
    .cout    (Cout1),
    .irq_nxt (irq_nxt[1])
  );

  always_comb begin
    rd_mux = '0;
    case (rsel)
      REG_CTRL0: rd_mux = stat0;
      REG_CTRL1: rd_mux = stat1;
      REG_CNT0:  rd_mux = count0;
      REG_CNT1:  rd_mux = count1;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) Read_data <= '0;
    else          Read_data <= rd ? {16'h0000, rd_mux} : 32'h0;
  end

`ifdef IO_TIMER_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) Irq <= 1'b0;
    else          Irq <= |irq_nxt;
  end
`else
  logic unused_irq;
  assign unused_irq = ^irq_nxt;
`endif

endmodule

// File: tb/tb_io_timer_responder.sv
// Bench for io_timer_responder: per-cycle expectations from a behavioural model
// are queued by the driver and checked by an independent monitor.
module tb_io_timer_responder;

  localparam logic [31:0] BASE  = 32'hFFFFFC20;
  localparam logic [31:0] A_ST0 = BASE + 32'h0;
  localparam logic [31:0] A_ST1 = BASE + 32'h2;
  localparam logic [31:0] A_CN0 = BASE + 32'h4;
  localparam logic [31:0] A_CN1 = BASE + 32'h6;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        IO_read = 1'b0;
  logic        IO_write = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic [31:0] Read_data;
  logic        Pulse_in0 = 1'b0;
  logic        Pulse_in1 = 1'b0;
  logic        Cout0, Cout1;
`ifdef IO_TIMER_IRQ_EN
  logic        Irq;
`endif

  int total = 0;
  int bad   = 0;

  // {irq, cout1, cout0, read_data}
  logic [34:0] exp_q[$];

  // Behavioural model state
  int m_init[2], m_cur[2];
  bit m_run[2], m_mode[2], m_rpt[2], m_irqen[2];
  bit [1:0] m_done[2];
  bit m_last[2], m_pipe0[2], m_pipe1[2];
  bit m_irq;
  bit p0 = 0, p1 = 0;

  io_timer_responder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .IO_read   (IO_read),
    .IO_write  (IO_write),
    .Address   (Address),
    .Write_data(Write_data),
    .Read_data (Read_data),
    .Pulse_in0 (Pulse_in0),
    .Pulse_in1 (Pulse_in1),
    .Cout0     (Cout0),
    .Cout1     (Cout1)
`ifdef IO_TIMER_IRQ_EN
    ,
    .Irq       (Irq)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_init[ch] = 0; m_cur[ch] = 0; m_run[ch] = 0; m_mode[ch] = 0;
      m_rpt[ch] = 0; m_irqen[ch] = 0; m_done[ch] = 0;
      m_last[ch] = 0; m_pipe0[ch] = 0; m_pipe1[ch] = 0;
    end
    m_irq = 0;
  endtask

  // Advance the model over one clock edge and return what the DUT should show after it.
  task automatic model_step(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [15:0] wd, input bit q0, input bit q1,
                            output logic [34:0] e);
    bit sel, do_rd, do_wr, dec, rise, pin;
    bit term[2];
    bit [1:0] set;
    int off;
    logic [31:0] rv;
    sel   = (rd || wr) && (addr[31:4] == BASE[31:4]);
    off   = int'(addr[3:0]);
    do_rd = sel && rd && !wr;
    do_wr = sel && wr;
    rv    = 32'h0;
    if (do_rd) begin
      case (off)
        0: rv = (32'(m_run[0]) << 15) | 32'(m_done[0]);
        2: rv = (32'(m_run[1]) << 15) | 32'(m_done[1]);
        4: rv = 32'(m_cur[0]);
        6: rv = 32'(m_cur[1]);
        default: rv = 32'h0;
      endcase
    end
    for (int ch = 0; ch < 2; ch++) begin
      pin = (ch == 0) ? q0 : q1;
      rise = pin && !m_last[ch];
      m_last[ch] = pin;
      dec = m_run[ch] && (m_mode[ch] ? m_pipe0[ch] : 1'b1);
      m_pipe0[ch] = m_pipe1[ch];
      m_pipe1[ch] = rise;
      term[ch] = dec && (m_cur[ch] == 1);
      set = term[ch] ? (m_mode[ch] ? 2'b10 : 2'b01) : 2'b00;
      if (dec) begin
        if (term[ch]) begin
          m_cur[ch] = m_rpt[ch] ? m_init[ch] : 0;
          m_run[ch] = m_rpt[ch];
        end else begin
          m_cur[ch] = m_cur[ch] - 1;
        end
      end
      m_done[ch] = ((do_rd && off == 2 * ch) ? 2'b00 : m_done[ch]) | set;
      if (do_wr && off == 2 * ch) begin
        m_mode[ch] = wd[0];
        m_rpt[ch]  = wd[1];
`ifdef IO_TIMER_IRQ_EN
        m_irqen[ch] = wd[2];
`else
        m_irqen[ch] = 1'b0;
`endif
      end
      if (do_wr && off == 4 + 2 * ch) begin
        m_init[ch] = int'(wd);
        m_cur[ch]  = int'(wd);
        m_run[ch]  = (wd != 16'h0);
      end
    end
    m_irq = (m_irqen[0] && m_done[0] != 0) || (m_irqen[1] && m_done[1] != 0);
    e = {m_irq, term[1], term[0], rv};
  endtask

  // Drive one bus cycle at a falling edge, queue its expectation, return at the next falling edge.
  task automatic cyc(input bit rd, input bit wr, input logic [31:0] addr, input logic [15:0] wd);
    logic [34:0] e;
    IO_read    = rd;
    IO_write   = wr;
    Address    = addr;
    Write_data = {16'($urandom), wd};
    Pulse_in0  = p0;
    Pulse_in1  = p1;
    model_step(rd, wr, addr, wd, p0, p1, e);
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [15:0] wd);
    cyc(1'b0, 1'b1, addr, wd);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 16'h0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    cyc(1'b1, 1'b0, addr, 16'h0);
    chk(name, Read_data, exp);
  endtask

  // Monitor: one expected entry per driven cycle, sampled 1ns after the edge.
  initial begin
    logic [34:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("read_data", Read_data, e[31:0]);
        chk("cout0", 32'(Cout0), 32'(e[32]));
        chk("cout1", 32'(Cout1), 32'(e[33]));
`ifdef IO_TIMER_IRQ_EN
        chk("irq", 32'(Irq), 32'(e[34]));
`endif
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    chk("reset_rd", Read_data, 32'h0);
    chk("reset_cout", {30'h0, Cout1, Cout0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Timer one-shot
    wr(A_ST0, 16'h0000);
    wr(A_CN0, 16'd5);
    for (int i = 1; i <= 6; i++) begin
      idle();
      chk("oneshot_cout0", 32'(Cout0), (i == 5) ? 32'h1 : 32'h0);
    end
    rd_chk("oneshot_stat_1", A_ST0, 32'h0001);
    rd_chk("oneshot_stat_2", A_ST0, 32'h0000);

    // Timer repeat
    wr(A_ST0, 16'h0002);
    wr(A_CN0, 16'd3);
    rd_chk("rpt_cnt3", A_CN0, 32'd3);
    rd_chk("rpt_cnt2", A_CN0, 32'd2);
    rd_chk("rpt_cnt1", A_CN0, 32'd1);
    chk("rpt_cout0", 32'(Cout0), 32'h1);
    rd_chk("rpt_stat_a", A_ST0, 32'h8001);
    rd_chk("rpt_stat_b", A_ST0, 32'h8000);
    idle();
    wr(A_CN0, 16'd0);
    rd_chk("rpt_stop_stat", A_ST0, 32'h0001);

    // Counter mode on channel 1
    wr(A_ST1, 16'h0001);
    wr(A_CN1, 16'd2);
    p1 = 1; idle();
    p1 = 0; idle(); idle();
    p1 = 1; idle(); chk("cnt_cout1_b0", 32'(Cout1), 32'h0);
    p1 = 0; idle(); chk("cnt_cout1_b1", 32'(Cout1), 32'h0);
    idle(); chk("cnt_cout1_b2", 32'(Cout1), 32'h1);
    idle(); chk("cnt_cout1_b3", 32'(Cout1), 32'h0);
    rd_chk("cnt_stat1", A_ST1, 32'h0002);

    // CNT write in terminal cycle
    wr(A_ST0, 16'h0000);
    wr(A_CN0, 16'd2);
    idle();
    wr(A_CN0, 16'd7);
    chk("coll_wr_cout0", 32'(Cout0), 32'h1);
    rd_chk("coll_wr_cnt", A_CN0, 32'd7);
    wr(A_CN0, 16'd0);
    rd_chk("coll_wr_stat", A_ST0, 32'h0001);

    // STAT read in terminal cycle
    wr(A_CN0, 16'd2);
    idle();
    rd_chk("coll_rd_stat", A_ST0, 32'h8000);
    rd_chk("coll_rd_after", A_ST0, 32'h0001);

    // Reset mid-count
    wr(A_CN0, 16'd5);
    repeat (3) idle();
    reset_n = 1'b0;
    IO_read = 1'b0;
    IO_write = 1'b0;
    #1;
    chk("rst_mid_rd", Read_data, 32'h0);
    chk("rst_mid_cout", {30'h0, Cout1, Cout0}, 32'h0);
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_hold_cout", {30'h0, Cout1, Cout0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);
    rd_chk("rst_stat0", A_ST0, 32'h0000);
    rd_chk("rst_cnt0", A_CN0, 32'h0000);

    // Decode
    rd_chk("dec_unmapped_rd", 32'hFFFFFC30, 32'h0);
    wr(32'hFFFFFC28, 16'd5);
    wr(32'hFFFFFD24, 16'd9);
    rd_chk("dec_cnt0", A_CN0, 32'h0);
    rd_chk("dec_stat0", A_ST0, 32'h0);
    cyc(1'b1, 1'b1, A_CN0, 16'd4);
    chk("both_rd", Read_data, 32'h0);
    rd_chk("both_cnt", A_CN0, 32'd4);
    wr(A_CN0, 16'd0);

`ifdef IO_TIMER_IRQ_EN
    wr(A_ST0, 16'h0004);
    wr(A_CN0, 16'd2);
    idle(); chk("irq_low", 32'(Irq), 32'h0);
    idle(); chk("irq_rise", 32'(Irq), 32'h1);
    idle(); chk("irq_hold", 32'(Irq), 32'h1);
    rd_chk("irq_stat", A_ST0, 32'h0001);
    chk("irq_fall", 32'(Irq), 32'h0);
    wr(A_ST0, 16'h0000);
`endif

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      int op;
      logic [31:0] a;
      logic [15:0] d;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0) a = BASE + 32'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 32'h10 : 32'h0);
      else a = BASE + 32'(2 * $urandom_range(0, 4));
      d = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) p0 = ~p0;
      if ($urandom_range(0, 2) == 0) p1 = ~p1;
      case (op)
        0, 1, 2, 3: cyc(1'b0, 1'b0, a, d);
        4, 5:       cyc(1'b1, 1'b0, a, d);
        6, 7, 8:    cyc(1'b0, 1'b1, a, d);
        default:    cyc(1'b1, 1'b1, a, d);
      endcase
    end

    IO_read = 1'b0;
    IO_write = 1'b0;
    repeat (2) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
